// File: rtl/booth_bist_pkg.sv
// Shared definitions for the Booth multiplier BIST controller.
// Holds the FSM state encoding, the shift-register mode encoding, the
// feedback tap mask (x^8+x^6+x^5+x^4+1, maximal length 255), the default
// seed and the step/seed helper functions.
package booth_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_CMP  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  typedef enum logic {
    MODE_LFSR = 1'b0,
    MODE_MISR = 1'b1
  } sr_mode_e;

  // Taps on bits 7,5,4,3 feed bit 0 after the left shift.
  localparam logic [7:0] TAP_MASK     = 8'hB8;
  localparam logic [7:0] DEFAULT_SEED = 8'h01;

  // One shift with feedback = parity of the tapped bits.
  function automatic logic [7:0] shift_step(input logic [7:0] v);
    return {v[6:0], ^(v & TAP_MASK)};
  endfunction

  // An all-zero LFSR is stuck; substitute the default seed.
  function automatic logic [7:0] legal_seed(input logic [7:0] s);
    return (s == 8'h00) ? DEFAULT_SEED : s;
  endfunction

endpackage

// File: rtl/booth_bist_ctrl_if.sv
// Control and datapath bus of the Booth BIST controller.
// slave  : the controller (drives operands, status and signature).
// master : test-access side plus multiplier datapath (drives start,
//          abort and the product).
interface booth_bist_ctrl_if;
  logic       start;
  logic       abort;
  logic [7:0] prod_in;
  logic [3:0] a_out;
  logic [3:0] b_out;
  logic       test_mode;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] sig_out;

  modport master (
    output start, abort, prod_in,
    input  a_out, b_out, test_mode, busy, done, pass, sig_out
  );

  modport slave (
    input  start, abort, prod_in,
    output a_out, b_out, test_mode, busy, done, pass, sig_out
  );
endinterface

// File: rtl/bist_lfsr_misr.sv
// 8-bit shift register with fixed tap mask, usable as LFSR or MISR.
// Ports: clk, rst_n (async, active low); load/load_val (parallel load,
// highest priority); step (advance one shift); mode (LFSR or MISR XOR-in
// of din); q_next (value the register takes at the next edge).
// q_next is exported instead of the current value so the parent can
// register its own output copies on the same edge as this register.
module bist_lfsr_misr
  import booth_bist_pkg::*;
#(
  parameter logic [7:0] RST_VAL = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       step,
  input  sr_mode_e   mode,
  input  logic [7:0] din,
  output logic [7:0] q_next
);

  logic [7:0] q_r;
  logic [7:0] q_next_s;

  // Next-value selection: load, shift (with optional XOR-in) or hold.
  always_comb begin
    q_next_s = q_r;
    if (load) begin
      q_next_s = load_val;
    end else if (step) begin
      if (mode == MODE_MISR) begin
        q_next_s = shift_step(q_r) ^ din;
      end else begin
        q_next_s = shift_step(q_r);
      end
    end else begin
      q_next_s = q_r;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r <= RST_VAL;
    end else begin
      q_r <= q_next_s;
    end
  end

  assign q_next = q_next_s;

endmodule

// File: rtl/booth_bist_ctrl.sv
// BIST sequencer for the 4x4 signed radix-4 Booth multiplier.
// An LFSR supplies operand pairs (a = lfsr[3:0], b = lfsr[7:4]), each held
// CUT_LAT+1 cycles; the product is folded into a MISR on the last cycle of
// each pattern. After N_PATTERNS samples the signature is compared with
// GOLDEN_SIG and done/pass are raised.
// Ports: clk, rst_n (async, active low), bus (slave modport: start, abort,
// prod_in in; a_out, b_out, test_mode, busy, done, pass, sig_out out).
module booth_bist_ctrl
  import booth_bist_pkg::*;
#(
  parameter int unsigned N_PATTERNS = 255,
  parameter logic [7:0]  SEED       = DEFAULT_SEED,
  parameter int unsigned CUT_LAT    = 0,
  parameter logic [7:0]  GOLDEN_SIG = 8'h00
) (
  input logic               clk,
  input logic               rst_n,
  booth_bist_ctrl_if.slave  bus
);

  localparam logic [1:0] LAT_LAST  = 2'(CUT_LAT);
  localparam logic [7:0] PAT_LAST  = 8'(N_PATTERNS - 1);
  localparam logic [7:0] LOAD_SEED = legal_seed(SEED);

  state_e     state_r;
  logic [1:0] lat_cnt_r;
  logic [7:0] pat_cnt_r;
  logic [3:0] a_out_r;
  logic [3:0] b_out_r;
  logic       test_mode_r;
  logic       busy_r;
  logic       done_r;
  logic       pass_r;
  logic [7:0] sig_out_r;

  logic       launch_s;
  logic       sample_s;
  logic [7:0] lfsr_nxt_s;
  logic [7:0] misr_nxt_s;

  // Load/step strobes shared by both shift registers; abort blocks both so
  // the MISR keeps its contents for debug.
  always_comb begin
    launch_s = 1'b0;
    sample_s = 1'b0;
    if (bus.abort) begin
      launch_s = 1'b0;
      sample_s = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: launch_s = bus.start;
        ST_RUN:           sample_s = (lat_cnt_r == LAT_LAST);
        default: begin
          launch_s = 1'b0;
          sample_s = 1'b0;
        end
      endcase
    end
  end

  bist_lfsr_misr #(.RST_VAL(8'h01)) u_lfsr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (launch_s),
    .load_val (LOAD_SEED),
    .step     (sample_s),
    .mode     (MODE_LFSR),
    .din      (8'h00),
    .q_next   (lfsr_nxt_s)
  );

  bist_lfsr_misr #(.RST_VAL(8'h00)) u_misr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (launch_s),
    .load_val (8'h00),
    .step     (sample_s),
    .mode     (MODE_MISR),
    .din      (bus.prod_in),
    .q_next   (misr_nxt_s)
  );

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      lat_cnt_r   <= 2'd0;
      pat_cnt_r   <= 8'd0;
      a_out_r     <= 4'h0;
      b_out_r     <= 4'h0;
      test_mode_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      pass_r      <= 1'b0;
      sig_out_r   <= 8'h00;
    end else begin
      sig_out_r <= misr_nxt_s;
      if (bus.abort) begin
        state_r     <= ST_IDLE;
        a_out_r     <= 4'h0;
        b_out_r     <= 4'h0;
        test_mode_r <= 1'b0;
        busy_r      <= 1'b0;
        done_r      <= 1'b0;
        pass_r      <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE, ST_DONE: begin
            if (bus.start) begin
              state_r     <= ST_RUN;
              lat_cnt_r   <= 2'd0;
              pat_cnt_r   <= 8'd0;
              a_out_r     <= lfsr_nxt_s[3:0];
              b_out_r     <= lfsr_nxt_s[7:4];
              test_mode_r <= 1'b1;
              busy_r      <= 1'b1;
              done_r      <= 1'b0;
              pass_r      <= 1'b0;
            end else begin
              state_r <= state_r;
            end
          end
          ST_RUN: begin
            if (lat_cnt_r == LAT_LAST) begin
              lat_cnt_r <= 2'd0;
              pat_cnt_r <= pat_cnt_r + 8'd1;
              if (pat_cnt_r == PAT_LAST) begin
                state_r <= ST_CMP;
                a_out_r <= 4'h0;
                b_out_r <= 4'h0;
              end else begin
                a_out_r <= lfsr_nxt_s[3:0];
                b_out_r <= lfsr_nxt_s[7:4];
              end
            end else begin
              lat_cnt_r <= lat_cnt_r + 2'd1;
            end
          end
          ST_CMP: begin
            // No load/step in CMP, so misr_nxt_s equals the final signature.
            state_r     <= ST_DONE;
            done_r      <= 1'b1;
            pass_r      <= (misr_nxt_s == GOLDEN_SIG);
            busy_r      <= 1'b0;
            test_mode_r <= 1'b0;
          end
          default: begin
            state_r <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.a_out     = a_out_r;
  assign bus.b_out     = b_out_r;
  assign bus.test_mode = test_mode_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.pass      = pass_r;
  assign bus.sig_out   = sig_out_r;

endmodule

// File: tb/tb_booth_bist_ctrl.sv
// Self-checking bench for booth_bist_ctrl. Four controllers with different
// parameter sets run side by side; a time-since-start reference model
// predicts every output each cycle, and literal expectations pin the model.
module tb_booth_bist_ctrl;

  function automatic logic [7:0] lfsr_next(input logic [7:0] x);
    return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
  endfunction

  // LFSR contents after p steps from a (sanitised) seed.
  function automatic logic [7:0] lfsr_at(input logic [7:0] seed, input int p);
    logic [7:0] x;
    x = (seed == 8'h00) ? 8'h01 : seed;
    for (int j = 0; j < p; j++) x = lfsr_next(x);
    return x;
  endfunction

  function automatic logic [7:0] smul(input logic [3:0] a, input logic [3:0] b);
    logic signed [7:0] sa;
    logic signed [7:0] sb;
    sa = {{4{a[3]}}, a};
    sb = {{4{b[3]}}, b};
    return sa * sb;
  endfunction

  function automatic logic [7:0] calc_golden(input logic [7:0] seed, input int n);
    logic [7:0] m;
    logic [7:0] x;
    m = 8'h00;
    x = seed;
    for (int j = 0; j < n; j++) begin
      m = lfsr_next(m) ^ smul(x[3:0], x[7:4]);
      x = lfsr_next(x);
    end
    return m;
  endfunction

  localparam logic [7:0] GOLD_FULL = calc_golden(8'h01, 255);
  localparam int         NP    [4] = '{1, 2, 255, 4};
  localparam int         LT    [4] = '{0, 0, 0, 2};
  localparam logic [7:0] SEEDM [4] = '{8'h01, 8'h01, 8'h01, 8'h00};
  localparam logic [7:0] GOLD  [4] = '{8'h00, 8'h00, GOLD_FULL, 8'h00};

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  booth_bist_ctrl_if if0 ();
  booth_bist_ctrl_if if1 ();
  booth_bist_ctrl_if if2 ();
  booth_bist_ctrl_if if3 ();

  booth_bist_ctrl #(.N_PATTERNS(1), .SEED(8'h01), .CUT_LAT(0), .GOLDEN_SIG(8'h00))
    u0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  booth_bist_ctrl #(.N_PATTERNS(2), .SEED(8'h01), .CUT_LAT(0), .GOLDEN_SIG(8'h00))
    u1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  booth_bist_ctrl #(.N_PATTERNS(255), .SEED(8'h01), .CUT_LAT(0), .GOLDEN_SIG(GOLD_FULL))
    u2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));
  booth_bist_ctrl #(.N_PATTERNS(4), .SEED(8'h00), .CUT_LAT(2), .GOLDEN_SIG(8'h00))
    u3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave));

  logic       st [4];
  logic       ab [4];
  logic       fault_en;
  logic       cov_on;
  int         pat2;
  logic [7:0] rnd3;

  assign if0.start = st[0];  assign if0.abort = ab[0];
  assign if1.start = st[1];  assign if1.abort = ab[1];
  assign if2.start = st[2];  assign if2.abort = ab[2];
  assign if3.start = st[3];  assign if3.abort = ab[3];

  // Datapath stand-ins: zero, constant, behavioural multiplier with optional
  // single-bit fault on prod[3] for pattern 100, and random per-cycle data.
  assign if0.prod_in = 8'h00;
  assign if1.prod_in = 8'h5A;
  assign if2.prod_in = smul(if2.a_out, if2.b_out) ^ ((fault_en && pat2 == 100) ? 8'h08 : 8'h00);
  assign if3.prod_in = rnd3;

  logic [3:0] da [4];
  logic [3:0] db [4];
  logic       dtm [4];
  logic       dbusy [4];
  logic       ddone [4];
  logic       dpass [4];
  logic [7:0] dsig [4];

  assign da[0] = if0.a_out;  assign db[0] = if0.b_out;  assign dtm[0] = if0.test_mode;
  assign da[1] = if1.a_out;  assign db[1] = if1.b_out;  assign dtm[1] = if1.test_mode;
  assign da[2] = if2.a_out;  assign db[2] = if2.b_out;  assign dtm[2] = if2.test_mode;
  assign da[3] = if3.a_out;  assign db[3] = if3.b_out;  assign dtm[3] = if3.test_mode;
  assign dbusy[0] = if0.busy; assign ddone[0] = if0.done; assign dpass[0] = if0.pass; assign dsig[0] = if0.sig_out;
  assign dbusy[1] = if1.busy; assign ddone[1] = if1.done; assign dpass[1] = if1.pass; assign dsig[1] = if1.sig_out;
  assign dbusy[2] = if2.busy; assign ddone[2] = if2.done; assign dpass[2] = if2.pass; assign dsig[2] = if2.sig_out;
  assign dbusy[3] = if3.busy; assign ddone[3] = if3.done; assign dpass[3] = if3.pass; assign dsig[3] = if3.sig_out;

  // Reference model: act = a run was launched and not aborted; k = cycles
  // since the launching edge; mm = signature accumulated so far.
  bit         act [4];
  int         k   [4];
  logic [7:0] mm  [4];
  int         occ [256];

  int n_checks;
  int n_errors;

  task automatic chk(input int i, input string nm, input logic [31:0] got, input logic [31:0] exp_v);
    n_checks++;
    if (got !== exp_v) begin
      n_errors++;
      $display("FAIL %s u%0d t=%0t: got %0h, expected %0h", nm, i, $time, got, exp_v);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      act[i] = 1'b0;
      k[i]   = 0;
      mm[i]  = 8'h00;
    end
    pat2 = -1;
  endtask

  // Apply the effect of the coming clock edge using the inputs now driven.
  task automatic model_edge();
    for (int i = 0; i < 4; i++) begin
      int t;
      logic [7:0] pm;
      logic [7:0] x;
      t = NP[i] * (LT[i] + 1);
      case (i)
        0: pm = 8'h00;
        1: pm = 8'h5A;
        2: begin
          x  = lfsr_at(SEEDM[2], k[2] - 1);
          pm = smul(x[3:0], x[7:4]) ^ ((fault_en && k[2] - 1 == 100) ? 8'h08 : 8'h00);
        end
        default: pm = rnd3;
      endcase
      if (ab[i]) begin
        act[i] = 1'b0;
      end else if ((!act[i] || k[i] >= t + 2) && st[i]) begin
        act[i] = 1'b1;
        k[i]   = 1;
        mm[i]  = 8'h00;
      end else if (act[i] && k[i] <= t + 1) begin
        if (k[i] <= t && (k[i] % (LT[i] + 1)) == 0) mm[i] = lfsr_next(mm[i]) ^ pm;
        k[i]++;
      end
    end
  endtask

  // Single compare routine: every output of every instance, every cycle.
  task automatic compare_all();
    for (int i = 0; i < 4; i++) begin
      int t;
      int p;
      logic [7:0] x;
      logic [3:0] ea;
      logic [3:0] eb;
      logic etm, ebusy, edone, epass;
      t = NP[i] * (LT[i] + 1);
      ea = 4'h0; eb = 4'h0; etm = 1'b0; ebusy = 1'b0; edone = 1'b0; epass = 1'b0;
      if (act[i]) begin
        if (k[i] <= t) begin
          p  = (k[i] - 1) / (LT[i] + 1);
          x  = lfsr_at(SEEDM[i], p);
          ea = x[3:0];
          eb = x[7:4];
          etm = 1'b1;
          ebusy = 1'b1;
        end else if (k[i] == t + 1) begin
          etm = 1'b1;
          ebusy = 1'b1;
        end else begin
          edone = 1'b1;
          epass = (mm[i] == GOLD[i]);
        end
      end
      chk(i, "a_out",     32'(da[i]),    32'(ea));
      chk(i, "b_out",     32'(db[i]),    32'(eb));
      chk(i, "test_mode", 32'(dtm[i]),   32'(etm));
      chk(i, "busy",      32'(dbusy[i]), 32'(ebusy));
      chk(i, "done",      32'(ddone[i]), 32'(edone));
      chk(i, "pass",      32'(dpass[i]), 32'(epass));
      chk(i, "sig_out",   32'(dsig[i]),  32'(mm[i]));
    end
    pat2 = (act[2] && k[2] <= NP[2]) ? k[2] - 1 : -1;
    if (cov_on && act[2] && k[2] <= NP[2]) occ[{db[2], da[2]}]++;
  endtask

  task automatic step();
    rnd3 = 8'($urandom);
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic pulse(input int i, input logic s, input logic a);
    st[i] = s;
    ab[i] = a;
    step();
    st[i] = 1'b0;
    ab[i] = 1'b0;
  endtask

  // Bounded wait for done; c0 is the cycle number already on display.
  task automatic run_to_done(input int i, input int exp_cyc, input int c0);
    int c;
    c = c0;
    while (ddone[i] !== 1'b1 && c < 400) begin
      step();
      c++;
    end
    chk(i, "done_cycle", 32'(c), 32'(exp_cyc));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int distinct;
    n_checks = 0;
    n_errors = 0;
    fault_en = 1'b0;
    cov_on   = 1'b0;
    rnd3     = 8'h00;
    for (int i = 0; i < 4; i++) begin
      st[i] = 1'b0;
      ab[i] = 1'b0;
    end
    for (int v = 0; v < 256; v++) occ[v] = 0;
    model_reset();
    rst_n = 1'b0;
    #3;
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Single pattern: operands 1/0 on cycle 1, done and pass on cycle 3.
    pulse(0, 1'b1, 1'b0);
    chk(0, "lit_a_c1", 32'(da[0]), 32'h1);
    chk(0, "lit_b_c1", 32'(db[0]), 32'h0);
    chk(0, "lit_busy_c1", 32'(dbusy[0]), 32'h1);
    run_to_done(0, 3, 1);
    chk(0, "lit_pass", 32'(dpass[0]), 32'h1);
    chk(0, "lit_sig", 32'(dsig[0]), 32'h00);
    repeat ($urandom_range(1, 3)) step();

    // Two patterns with constant 0x5A. 0x5A has taps b7,b5,b4,b3 = 0,0,1,1,
    // so feedback is 0 and the second sample gives 0xB4 ^ 0x5A = 0xEE.
    pulse(1, 1'b1, 1'b0);
    step();
    chk(1, "lit_a_pat2", 32'(da[1]), 32'h2);
    chk(1, "lit_b_pat2", 32'(db[1]), 32'h0);
    chk(1, "lit_sig_first", 32'(dsig[1]), 32'h5A);
    run_to_done(1, 4, 2);
    chk(1, "lit_sig_final", 32'(dsig[1]), 32'hEE);
    chk(1, "lit_pass_final", 32'(dpass[1]), 32'h0);
    repeat ($urandom_range(1, 3)) step();

    // CUT_LAT=2, zero seed replaced by 1, random product; start mid-run ignored.
    pulse(3, 1'b1, 1'b0);
    chk(3, "lit_hold_c1", 32'(da[3]), 32'h1);
    step();
    chk(3, "lit_hold_c2", 32'(da[3]), 32'h1);
    step();
    chk(3, "lit_hold_c3", 32'(da[3]), 32'h1);
    step();
    chk(3, "lit_next_c4", 32'(da[3]), 32'h2);
    pulse(3, 1'b1, 1'b0);
    run_to_done(3, 14, 5);
    repeat ($urandom_range(1, 3)) step();

    // Full run against the behavioural multiplier.
    cov_on = 1'b1;
    pulse(2, 1'b1, 1'b0);
    run_to_done(2, 257, 1);
    cov_on = 1'b0;
    chk(2, "full_pass", 32'(dpass[2]), 32'h1);
    chk(2, "full_sig", 32'(dsig[2]), 32'(GOLD_FULL));
    distinct = 0;
    for (int v = 1; v < 256; v++) if (occ[v] == 1) distinct++;
    chk(2, "pairs_once", 32'(distinct), 32'd255);
    chk(2, "zero_pair", 32'(occ[0]), 32'd0);
    repeat ($urandom_range(1, 3)) step();

    // Same run with prod[3] flipped on pattern 100.
    fault_en = 1'b1;
    pulse(2, 1'b1, 1'b0);
    run_to_done(2, 257, 1);
    chk(2, "fault_pass", 32'(dpass[2]), 32'h0);
    chk(2, "fault_sig_differs", 32'(dsig[2] != GOLD_FULL), 32'h1);
    fault_en = 1'b0;
    repeat ($urandom_range(1, 3)) step();

    // Abort together with start during cycle 50; later restart from SEED.
    pulse(2, 1'b1, 1'b0);
    repeat (49) step();
    pulse(2, 1'b1, 1'b1);
    chk(2, "abort_busy", 32'(dbusy[2]), 32'h0);
    chk(2, "abort_tm", 32'(dtm[2]), 32'h0);
    chk(2, "abort_done", 32'(ddone[2]), 32'h0);
    repeat ($urandom_range(2, 5)) step();
    pulse(2, 1'b1, 1'b0);
    chk(2, "restart_a", 32'(da[2]), 32'h1);
    chk(2, "restart_b", 32'(db[2]), 32'h0);
    run_to_done(2, 257, 1);
    chk(2, "restart_pass", 32'(dpass[2]), 32'h1);

    // Asynchronous reset mid-run clears everything immediately.
    pulse(2, 1'b1, 1'b0);
    repeat (20) step();
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    compare_all();
    chk(2, "rst_busy", 32'(dbusy[2]), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    pulse(0, 1'b1, 1'b0);
    run_to_done(0, 3, 1);
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
